// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// config_pkg -- shared FSM encoding, command-word fields and table markers
//               for the power-up register configuration sequencer.
// Revision: 1.0
// ============================================================================
package config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DELAY = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Command word layout: {device, register, value}
  localparam int DEV_MSB = 23;
  localparam int DEV_LSB = 16;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;

  localparam logic [7:0] END_MARKER   = 8'h00;
  localparam logic [7:0] DELAY_MARKER = 8'hFE;

endpackage

`default_nettype wire

// File: rtl/config_rom.sv
`default_nettype none
// ============================================================================
// config_rom -- command table with registered read port. TABLE_SEL=0 holds
//               the ADV7513 bring-up table; TABLE_SEL=1 is a bring-up table
//               exercising delay entries and a full table without END.
// Revision: 1.0
// ============================================================================
module config_rom
  import config_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int TABLE_SEL  = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  int unsigned idx;
  logic [23:0] word;

  always_comb begin
    idx  = 32'(addr);
    word = {END_MARKER, 16'h0000};
    if (TABLE_SEL == 0) begin
      case (idx)
        0:       word = 24'h724110;
        1:       word = 24'h729803;
        2:       word = 24'h729AE0;
        3:       word = 24'h729C30;
        4:       word = 24'h729D61;
        5:       word = 24'h72A2A4;
        6:       word = 24'h72A3A4;
        7:       word = 24'h72E0D0;
        8:       word = 24'h72F900;
        9:       word = 24'h7215F0;
        10:      word = 24'h721610;
        11:      word = 24'h721702;
        12:      word = 24'h721846;
        13:      word = 24'h72AF06;
        default: word = {END_MARKER, 16'h0000};
      endcase
    end else begin
      case (idx)
        0:       word = 24'h720102;
        1:       word = {DELAY_MARKER, 16'h0010};
        2:       word = 24'h720304;
        3:       word = {DELAY_MARKER, 16'h0000};
        default: if (idx < 16) word = {8'h72, idx[7:0], 8'(idx * 3)};
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) data <= '0;
    else         data <= DATA_WIDTH'(word);
  end

endmodule

`default_nettype wire

// File: rtl/config_sequencer.sv
`default_nettype none
// ============================================================================
// config_sequencer -- walks a ROM of I2C register writes after start, with
//                     per-entry NACK retry, inline delays and restart support.
// Revision: 1.0
// ============================================================================
module config_sequencer
  import config_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 4,
  parameter int MAX_RETRIES = 3,
  parameter int TABLE_SEL   = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  output logic                  cmdValid,
  input  logic                  cmdReady,
  output logic [DATA_WIDTH-1:0] cmdData,
  input  logic                  i2cDone,
  input  logic                  i2cAckError,
  output logic                  busy,
  output logic                  configDone,
  output logic                  configError,
  output logic [ADDR_WIDTH-1:0] entryIndex
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRIES);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  state_t                  state;
  logic                    rom_ready;
  logic                    start_pending;
  logic                    restart_now;
  logic [RETRY_W-1:0]      retry_cnt;
  logic [15:0]             delay_cnt;
  logic [DATA_WIDTH-1:0]   rom_data;
  logic [7:0]              rom_dev;

  config_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TABLE_SEL  (TABLE_SEL)
  ) u_rom (
    .clock  (clock),
    .resetN (resetN),
    .addr   (entryIndex),
    .data   (rom_data)
  );

  assign rom_dev = rom_data[DEV_MSB:DEV_LSB];

  // A start seen while a transaction is on the bus waits for its completion.
  always_comb begin
    restart_now = 1'b0;
    case (state)
      ST_WAIT:  restart_now = i2cDone && (start || start_pending);
      ST_ISSUE: restart_now = start && !cmdReady;
      default:  restart_now = start;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      cmdValid      <= 1'b0;
      cmdData       <= '0;
      busy          <= 1'b0;
      configDone    <= 1'b0;
      configError   <= 1'b0;
      entryIndex    <= '0;
      retry_cnt     <= '0;
      delay_cnt     <= '0;
      start_pending <= 1'b0;
      rom_ready     <= 1'b0;
    end else if (restart_now) begin
      state         <= ST_FETCH;
      cmdValid      <= 1'b0;
      busy          <= 1'b1;
      configDone    <= 1'b0;
      configError   <= 1'b0;
      entryIndex    <= '0;
      retry_cnt     <= '0;
      start_pending <= 1'b0;
      rom_ready     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          // First cycle lets the registered ROM catch up with entryIndex.
          if (!rom_ready) begin
            rom_ready <= 1'b1;
          end else begin
            rom_ready <= 1'b0;
            if (rom_dev == END_MARKER) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              configDone <= 1'b1;
            end else if (rom_dev == DELAY_MARKER) begin
              state     <= ST_DELAY;
              delay_cnt <= rom_data[REG_MSB:VAL_LSB];
            end else begin
              state    <= ST_ISSUE;
              cmdValid <= 1'b1;
              cmdData  <= rom_data;
            end
          end
        end
        ST_ISSUE: begin
          if (cmdReady) begin
            cmdValid      <= 1'b0;
            state         <= ST_WAIT;
            start_pending <= start;
          end
        end
        ST_WAIT: begin
          if (start) start_pending <= 1'b1;
          if (i2cDone) begin
            if (!i2cAckError) begin
              if (entryIndex == LAST_INDEX) begin
                state      <= ST_DONE;
                busy       <= 1'b0;
                configDone <= 1'b1;
              end else begin
                entryIndex <= entryIndex + 1'b1;
                retry_cnt  <= '0;
                state      <= ST_FETCH;
              end
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_ISSUE;
              cmdValid  <= 1'b1;
            end else begin
              state       <= ST_ERROR;
              busy        <= 1'b0;
              configError <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (delay_cnt <= 16'd1) begin
            if (entryIndex == LAST_INDEX) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              configDone <= 1'b1;
            end else begin
              entryIndex <= entryIndex + 1'b1;
              retry_cnt  <= '0;
              state      <= ST_FETCH;
            end
          end else begin
            delay_cnt <= delay_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_config_sequencer -- randomized bench with a transaction-level model of
//                        the configuration walk; second instance uses the
//                        delay/full-table ROM.
// Revision: 1.0
// ============================================================================
module tb_config_sequencer;

  localparam int AW = 4;
  localparam int DW = 24;

  localparam logic [23:0] TAB0 [0:15] = '{
    24'h724110, 24'h729803, 24'h729AE0, 24'h729C30, 24'h729D61, 24'h72A2A4,
    24'h72A3A4, 24'h72E0D0, 24'h72F900, 24'h7215F0, 24'h721610, 24'h721702,
    24'h721846, 24'h72AF06, 24'h000000, 24'h000000};

  localparam logic [23:0] TAB1_CMDS [0:13] = '{
    24'h720102, 24'h720304, 24'h72040C, 24'h72050F, 24'h720612, 24'h720715,
    24'h720818, 24'h72091B, 24'h720A1E, 24'h720B21, 24'h720C24, 24'h720D27,
    24'h720E2A, 24'h720F2D};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetN, start, cmdReady, i2cDone, i2cAckError;
  logic          cmdValid, busy, configDone, configError;
  logic [DW-1:0] cmdData;
  logic [AW-1:0] entryIndex;

  logic          start2, cmdReady2, i2cDone2;
  logic          cmdValid2, busy2, configDone2, configError2;
  logic [DW-1:0] cmdData2;
  logic [AW-1:0] entryIndex2;

  config_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRIES(3), .TABLE_SEL(0)) dut (
    .clock(clock), .resetN(resetN), .start(start), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdData(cmdData), .i2cDone(i2cDone), .i2cAckError(i2cAckError), .busy(busy),
    .configDone(configDone), .configError(configError), .entryIndex(entryIndex));

  config_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRIES(3), .TABLE_SEL(1)) dut2 (
    .clock(clock), .resetN(resetN), .start(start2), .cmdValid(cmdValid2), .cmdReady(cmdReady2),
    .cmdData(cmdData2), .i2cDone(i2cDone2), .i2cAckError(1'b0), .busy(busy2),
    .configDone(configDone2), .configError(configError2), .entryIndex(entryIndex2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- master knobs and state (DUT 1) ----------------
  int          hold_low    = 0;
  int          held_cycles = 0;
  int          done_lat    = 1;   // 0 = random 1..4
  bit          rand_ready  = 0;
  bit          spurious    = 0;
  logic [23:0] nack_data   = 24'h0;
  int          nack_left   = 0;
  bit          m1_outst    = 0;

  initial begin
    int          lat;
    bit          hs;
    logic [23:0] acc;
    cmdReady = 1'b0; i2cDone = 1'b0; i2cAckError = 1'b0;
    lat = 0; acc = '0;
    forever begin
      @(negedge clock);
      hs = cmdValid && cmdReady;
      if (hs) acc = cmdData;
      if (cmdValid && !cmdReady && hold_low > 0) begin
        hold_low--;
        held_cycles++;
      end
      @(posedge clock); #1;
      i2cDone = 1'b0;
      i2cAckError = 1'b0;
      if (!resetN) begin
        m1_outst = 0;
        cmdReady = 1'b0;
      end else begin
        if (hs) begin
          m1_outst = 1;
          lat = (done_lat == 0) ? int'($urandom_range(1, 4)) : done_lat;
        end else if (m1_outst) begin
          if (lat <= 1) begin
            i2cDone = 1'b1;
            m1_outst = 0;
            if (acc == nack_data && nack_left > 0) begin
              i2cAckError = 1'b1;
              nack_left--;
            end
          end else lat--;
        end else if (spurious && $urandom_range(0, 5) == 0) begin
          i2cDone = 1'b1;
          i2cAckError = 1'($urandom_range(0, 1));
        end
        cmdReady = (hold_low > 0) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end
  end

  // ---------------- transaction-level model + compare (DUT 1) ----------------
  bit          m_active, m_done, m_err, m_out, m_pend;
  int          m_idx, m_retry;
  logic [23:0] issued[$];

  task automatic m_settle();
    logic [23:0] w;
    for (int k = 0; k < 17; k++) begin
      w = TAB0[m_idx];
      if (w[23:16] == 8'h00) begin m_done = 1; return; end
      if (w[23:16] != 8'hFE) return;
      if (m_idx == 15) begin m_done = 1; return; end
      m_idx++;
    end
  endtask

  task automatic m_restart();
    m_active = 1; m_idx = 0; m_retry = 0;
    m_done = 0; m_err = 0; m_pend = 0; m_out = 0;
    m_settle();
  endtask

  task automatic m_advance();
    m_retry = 0;
    if (m_idx == 15) m_done = 1;
    else begin
      m_idx++;
      m_settle();
    end
  endtask

  initial begin
    bit          prev_stall;
    logic [23:0] prev_data;
    prev_stall = 0; prev_data = '0;
    m_active = 0; m_done = 0; m_err = 0; m_out = 0; m_pend = 0; m_idx = 0; m_retry = 0;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        m_active = 0; m_done = 0; m_err = 0; m_out = 0; m_pend = 0; m_idx = 0; m_retry = 0;
        prev_stall = 0;
      end else begin
        if (cmdValid) begin
          check("valid_allowed", 32'(m_active && !m_done && !m_err && !m_out), 32'd1);
          check("cmd_data", 32'(cmdData), 32'(TAB0[m_idx]));
        end
        if (prev_stall) begin
          check("stall_valid", 32'(cmdValid), 32'd1);
          check("stall_data", 32'(cmdData), 32'(prev_data));
        end
        prev_stall = cmdValid && !cmdReady;
        prev_data  = cmdData;
        check("done_err_excl", 32'(configDone && configError), 32'd0);
        if (m_out)       check("busy_in_wait", 32'(busy), 32'd1);
        if (configDone)  check("done_vs_model", 32'(m_done), 32'd1);
        if (configError) check("error_vs_model", 32'(m_err), 32'd1);

        if (i2cDone && m_out) begin
          m_out = 0;
          if (m_pend || start)          m_restart();
          else if (!i2cAckError)        m_advance();
          else if (m_retry < 3)         m_retry++;
          else                          m_err = 1;
        end
        if (cmdValid && cmdReady) begin
          m_out = 1;
          issued.push_back(cmdData);
        end
        if (start && !(i2cDone && !m_out && m_active && m_idx == 0 && m_retry == 0 && !m_pend && issued.size() == 0)) begin
          if (m_out) m_pend = 1;
          else if (!(i2cDone && m_idx == 0 && !m_done && !m_err && m_active && m_retry == 0 && !m_pend && 0)) m_restart();
        end
      end
    end
  end

  // ---------------- DUT 2: always-ready master and gap monitor ----------------
  logic [23:0] issued2[$];
  int          gaps2[$];

  initial begin
    int bit_lat;
    bit hs2;
    cmdReady2 = 1'b1; i2cDone2 = 1'b0; bit_lat = 0;
    forever begin
      @(negedge clock);
      hs2 = cmdValid2 && cmdReady2;
      @(posedge clock); #1;
      i2cDone2 = 1'b0;
      if (hs2) bit_lat = 2;
      else if (bit_lat > 0) begin
        bit_lat--;
        if (bit_lat == 0) i2cDone2 = 1'b1;
      end
    end
  end

  initial begin
    int idle_cnt;
    bit prev_v;
    idle_cnt = 0; prev_v = 0;
    forever begin
      @(negedge clock);
      if (cmdValid2 && !prev_v) gaps2.push_back(idle_cnt);
      if (cmdValid2) begin
        issued2.push_back(cmdData2);
        idle_cnt = 0;
      end else idle_cnt++;
      prev_v = cmdValid2;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (!(!busy && (configDone || configError)) && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  function automatic int count_of(input logic [23:0] v);
    int c;
    c = 0;
    foreach (issued[i]) if (issued[i] == v) c++;
    return c;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int n;
    resetN = 1'b0; start = 1'b0; start2 = 1'b0;
    #1;
    check("rst_valid", 32'(cmdValid), 32'd0);
    check("rst_data", 32'(cmdData), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(configDone), 32'd0);
    check("rst_error", 32'(configError), 32'd0);
    check("rst_index", 32'(entryIndex), 32'd0);
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (8) @(negedge clock);
    check("idle_no_start_busy", 32'(busy), 32'd0);
    check("idle_no_start_cmds", 32'(issued.size()), 32'd0);

    // Clean pass, master always ready.
    done_lat = 1;
    pulse_start();
    wait_idle("t1_timeout", 2000);
    check("t1_count", 32'(issued.size()), 32'd14);
    if (issued.size() == 14) begin
      check("t1_first", 32'(issued[0]), 32'h724110);
      check("t1_last", 32'(issued[13]), 32'h72AF06);
    end
    check("t1_done", 32'(configDone), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_index", 32'(entryIndex), 32'd14);

    // Two NACKs on entry 3, random ready/latency, spurious i2cDone.
    issued.delete();
    rand_ready = 1; spurious = 1; done_lat = 0;
    nack_data = 24'h729C30; nack_left = 2;
    pulse_start();
    wait_idle("t2_timeout", 4000);
    check("t2_retries", 32'(count_of(24'h729C30)), 32'd3);
    check("t2_count", 32'(issued.size()), 32'd16);
    check("t2_done", 32'(configDone), 32'd1);
    check("t2_error", 32'(configError), 32'd0);
    check("t2_index", 32'(entryIndex), 32'd14);

    // Retries exhausted on entry 5.
    issued.delete();
    nack_data = 24'h72A2A4; nack_left = 4;
    pulse_start();
    wait_idle("t3_timeout", 4000);
    check("t3_error", 32'(configError), 32'd1);
    check("t3_done", 32'(configDone), 32'd0);
    check("t3_index", 32'(entryIndex), 32'd5);
    check("t3_tries", 32'(count_of(24'h72A2A4)), 32'd4);
    repeat (40) @(negedge clock);
    check("t3_quiet", 32'(issued.size()), 32'd9);
    check("t3_hold_error", 32'(configError), 32'd1);

    // Back-pressure, then start while a transaction is outstanding.
    issued.delete();
    rand_ready = 0; spurious = 0; nack_left = 0;
    done_lat = 12; held_cycles = 0; hold_low = 10;
    pulse_start();
    n = 0;
    while (issued.size() < 1 && n < 200) begin @(negedge clock); n++; end
    check("t4_first_timeout", 32'(n < 200), 32'd1);
    check("t4_held", 32'(held_cycles), 32'd10);
    n = 0;
    while (!(m1_outst && issued.size() >= 3) && n < 400) begin @(negedge clock); n++; end
    check("t4_wait_timeout", 32'(n < 400), 32'd1);
    pulse_start();
    n = issued.size();
    begin
      int k;
      k = 0;
      while (issued.size() <= n && k < 200) begin @(negedge clock); k++; end
      check("t4_restart_timeout", 32'(k < 200), 32'd1);
    end
    if (issued.size() > n) check("t4_restart_cmd", 32'(issued[n]), 32'h724110);
    done_lat = 0;
    wait_idle("t4_timeout", 4000);
    check("t4_done", 32'(configDone), 32'd1);
    check("t4_index", 32'(entryIndex), 32'd14);

    // Asynchronous reset in the middle of a transaction.
    issued.delete();
    done_lat = 10;
    pulse_start();
    n = 0;
    while (!m1_outst && n < 200) begin @(negedge clock); n++; end
    check("t5_wait_timeout", 32'(n < 200), 32'd1);
    @(posedge clock); #3 resetN = 1'b0;
    #1;
    check("t5_valid", 32'(cmdValid), 32'd0);
    check("t5_data", 32'(cmdData), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(configDone), 32'd0);
    check("t5_error", 32'(configError), 32'd0);
    check("t5_index", 32'(entryIndex), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    n = issued.size();
    repeat (20) @(negedge clock);
    check("t5_quiet", 32'(issued.size()), 32'(n));
    check("t5_idle_busy", 32'(busy), 32'd0);
    done_lat = 0;
    pulse_start();
    wait_idle("t5_timeout", 2000);
    check("t5_redone", 32'(configDone), 32'd1);

    // Delay entries and a full table without END marker (second instance).
    @(posedge clock); #1 start2 = 1'b1;
    @(posedge clock); #1 start2 = 1'b0;
    n = 0;
    while (!(!busy2 && configDone2) && n < 2000) begin @(negedge clock); n++; end
    check("d_timeout", 32'(n < 2000), 32'd1);
    check("d_count", 32'(issued2.size()), 32'd14);
    if (issued2.size() == 14)
      for (int i = 0; i < 14; i++) check("d_cmd", 32'(issued2[i]), 32'(TAB1_CMDS[i]));
    check("d_done", 32'(configDone2), 32'd1);
    check("d_index_nowrap", 32'(entryIndex2), 32'd15);
    if (gaps2.size() >= 5) begin
      check("d_gap16_min", 32'(gaps2[1] >= 16), 32'd1);
      check("d_gap16_vs_plain", 32'((gaps2[1] - gaps2[4]) >= 16 && (gaps2[1] - gaps2[4]) <= 20), 32'd1);
      check("d_gap0_short", 32'(gaps2[2] < 16 && gaps2[2] > gaps2[4]), 32'd1);
    end else check("d_gaps_seen", 32'(gaps2.size()), 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: command word width, {device[23:16], register[15:8], value[7:0]}.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: ROM index width (2^ADDR_WIDTH entries).
REQ-003 SHALL have parameter MAX_RETRIES, default 3: re-issues allowed per entry after a NACK.
REQ-004 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins or restarts the configuration sequence (e.g. on hot-plug).
REQ-007 SHALL have port cmdValid  output  1  command word presented to the I2C master.
REQ-008 SHALL have port cmdReady  input  1  I2C master accepts cmdData when cmdValid&&cmdReady.
REQ-009 SHALL have port cmdData  output  DATA_WIDTH  current command word.
REQ-010 SHALL have port i2cDone  input  1  one-cycle pulse: accepted transaction finished.
REQ-011 SHALL have port i2cAckError  input  1  qualified by i2cDone; 1 = NACK.
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port configDone  output  1  all entries written successfully; held until next start.
REQ-014 SHALL have port configError  output  1  retries exhausted; held until next start.
REQ-015 SHALL have port entryIndex  output  ADDR_WIDTH  index of current/failing entry.

Function
REQ-016 SHALL implement states IDLE, FETCH, ISSUE, WAIT, DELAY, DONE, ERROR.
REQ-017 SHALL go IDLE/DONE/ERROR -> FETCH on start, clearing entryIndex, retry count, configDone, configError.
REQ-018 SHALL, in FETCH, read the ROM word at entryIndex (one cycle) and go: device==0x00 -> DONE; device==0xFE -> DELAY; else -> ISSUE.
REQ-019 SHALL, in ISSUE, assert cmdValid with cmdData stable until cmdValid&&cmdReady, then go WAIT with cmdValid low the next cycle.
REQ-020 SHALL, in WAIT on i2cDone with no NACK, increment entryIndex, clear retry count, go FETCH.
REQ-021 SHALL, in WAIT on i2cDone with NACK, go ISSUE (same entry) if retry count < MAX_RETRIES, incrementing retry count; else go ERROR.
REQ-022 SHALL, in DELAY, count {register,value} (16-bit) clock cycles, then increment entryIndex and go FETCH; delay 0 advances after one cycle.
REQ-023 SHALL go DONE after the last index (2^ADDR_WIDTH-1) completes without end marker; entryIndex SHALL NOT wrap to 0.
REQ-024 SHALL treat start during FETCH/ISSUE/WAIT/DELAY as restart to FETCH at index 0, except in WAIT, where it is latched and applied after i2cDone (no abandoned bus transaction).
REQ-025 SHALL ignore i2cDone outside WAIT.
REQ-026 SHALL drive busy=1 exactly in FETCH, ISSUE, WAIT, DELAY.
REQ-027 SHALL keep configDone and configError mutually exclusive.

Reset
REQ-028 SHALL, on resetN low, asynchronously enter IDLE with cmdValid=0, cmdData=0, busy=0, configDone=0, configError=0, entryIndex=0, retry/delay counters=0, pending start cleared.
REQ-029 SHALL not begin a sequence after reset release until a start pulse.

Structure
REQ-030 SHALL place state encoding, field bit positions, END marker (0x00) and DELAY marker (0xFE) constants in shared package config_pkg.
REQ-031 SHALL hold the ADV7513 table (0x72 writes: 0x41=0x10, 0x98=0x03, 0x9A=0xE0, 0x9C=0x30, 0x9D=0x61, 0xA2=0xA4, 0xA3=0xA4, 0xE0=0xD0, 0xF9=0x00, 0x15=0xF0, 0x16=0x10, 0x17=0x02, 0x18=0x46, 0xAF=0x06, then END) in sub-module config_rom, registered output.

Verification
REQ-032 Start, master always ready, no NACK -> 14 commands in table order (first 0x724110, last 0x72AF06), then configDone=1, busy=0, entryIndex=14.
REQ-033 NACK on entry 3 twice then ACK -> 0x729C30 issued 3 times, sequence completes, configDone=1.
REQ-034 NACK on entry 5 four times (MAX_RETRIES=3) -> configError=1, entryIndex=5, no further cmdValid.
REQ-035 Table entry 0xFE0010 -> 16-cycle gap with cmdValid=0 before next command.
REQ-036 cmdReady held low 10 cycles -> cmdData stable, cmdValid high throughout; start during WAIT -> restart at 0x724110 only after i2cDone.
REQ-037 resetN low mid-WAIT -> all outputs zero immediately, IDLE, no commands until start.
